// File: rtl/tfc_delay_ctrl_if.sv
// Request/ack, TFC monitor and delay-line control bundle for tfc_delay_ctrl.
// The controller takes the slave modport; the requesters/stimulus side take the master modport.
interface tfc_delay_ctrl_if #(
    parameter int unsigned TFC_WIDTH = 8
);
    logic                 sc_req;
    logic [7:0]           sc_len;
    logic                 sc_ack;
    logic                 cal_req;
    logic [7:0]           cal_len;
    logic                 cal_ack;
    logic [TFC_WIDTH-1:0] tfc_in;
    logic [7:0]           fifo_len;
    logic                 blank;
    logic                 busy;
    logic                 err_range;
    logic                 sync_timeout;

    modport master (
        output sc_req, sc_len, cal_req, cal_len, tfc_in,
        input  sc_ack, cal_ack, fifo_len, blank, busy, err_range, sync_timeout
    );

    modport slave (
        input  sc_req, sc_len, cal_req, cal_len, tfc_in,
        output sc_ack, cal_ack, fifo_len, blank, busy, err_range, sync_timeout
    );
endinterface

// File: rtl/tfc_delay_ctrl.sv
// TFC delay-line tap controller: arbitrates slow-control/calibration requests, applies taps on sync, then blanks.
// All outputs registered; ack 1 cycle after a reject, 1 cycle after sync (or timeout) for a change; requests wait while busy.
module tfc_delay_ctrl #(
    parameter int unsigned TFC_WIDTH    = 8,
    parameter int unsigned MAX_LEN      = 255,
    parameter int unsigned RESET_LEN    = 0,
    parameter int unsigned SYNC_BIT     = 0,
    parameter int unsigned BLANK_EXTRA  = 2,
    parameter int unsigned SYNC_TIMEOUT = 4095
) (
    input  logic                 main_clk,
    input  logic                 rst_n,
    tfc_delay_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        BLANK = 2'd2
    } state_e;

    localparam int unsigned SYNC_IDX  = (SYNC_BIT < TFC_WIDTH) ? SYNC_BIT : 0;
    localparam logic [7:0]  MAX8      = 8'(MAX_LEN);
    localparam logic [7:0]  RESET8    = 8'(RESET_LEN);
    localparam logic [15:0] TMO_LIM   = 16'(SYNC_TIMEOUT);
    localparam logic [9:0]  EXTRA10   = 10'(BLANK_EXTRA + 1);

    state_e      state_q, state_d;
    logic [7:0]  fifo_len_q, fifo_len_d;
    logic [7:0]  len_q, len_d;
    logic        id_q, id_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [8:0]  blank_cnt_q, blank_cnt_d;
    logic        sc_ack_q, sc_ack_d;
    logic        cal_ack_q, cal_ack_d;
    logic        err_q, err_d;
    logic        tmo_pulse_q, tmo_pulse_d;
    logic        blank_q, blank_d;
    logic        busy_q, busy_d;

    logic        sc_ok, cal_ok;
    logic [7:0]  grant_len;
    logic        sync_hit, tmo_hit;
    logic [7:0]  up_diff;
    logic [9:0]  blank_sum;
    logic [8:0]  blank_n;

    // A requester whose ack is on the wire this cycle still has req high; skip it once.
    assign sc_ok     = bus.sc_req & ~sc_ack_q;
    assign cal_ok    = bus.cal_req & ~cal_ack_q;
    assign grant_len = sc_ok ? bus.sc_len : bus.cal_len;
    assign sync_hit  = bus.tfc_in[SYNC_IDX];
    assign tmo_hit   = (tmo_cnt_q == TMO_LIM);
    assign up_diff   = (len_q > fifo_len_q) ? (len_q - fifo_len_q) : 8'd0;
    assign blank_sum = {2'b00, up_diff} + EXTRA10;
    assign blank_n   = (blank_sum > 10'd511) ? 9'h1FF : blank_sum[8:0];

    always_comb begin
        state_d     = state_q;
        fifo_len_d  = fifo_len_q;
        len_d       = len_q;
        id_d        = id_q;
        tmo_cnt_d   = tmo_cnt_q;
        blank_cnt_d = blank_cnt_q;
        sc_ack_d    = 1'b0;
        cal_ack_d   = 1'b0;
        err_d       = 1'b0;
        tmo_pulse_d = 1'b0;
        blank_d     = blank_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (sc_ok || cal_ok) begin
                    if (grant_len > MAX8 || grant_len == fifo_len_q) begin
                        sc_ack_d  = sc_ok;
                        cal_ack_d = ~sc_ok;
                        err_d     = (grant_len > MAX8);
                    end else begin
                        len_d     = grant_len;
                        id_d      = ~sc_ok;
                        tmo_cnt_d = 16'd0;
                        busy_d    = 1'b1;
                        state_d   = ARM;
                    end
                end
            end
            ARM: begin
                if (sync_hit || tmo_hit) begin
                    fifo_len_d  = len_q;
                    sc_ack_d    = ~id_q;
                    cal_ack_d   = id_q;
                    tmo_pulse_d = ~sync_hit;
                    blank_cnt_d = blank_n;
                    blank_d     = 1'b1;
                    state_d     = BLANK;
                end else if (tmo_cnt_q != 16'hFFFF) begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            BLANK: begin
                // Counter holds the blank cycles still to show, including the current one.
                if (blank_cnt_q <= 9'd1) begin
                    blank_cnt_d = 9'd0;
                    blank_d     = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    blank_cnt_d = blank_cnt_q - 9'd1;
                end
            end
            default: begin
                state_d = IDLE;
                blank_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fifo_len_q  <= RESET8;
            len_q       <= 8'd0;
            id_q        <= 1'b0;
            tmo_cnt_q   <= 16'd0;
            blank_cnt_q <= 9'd0;
            sc_ack_q    <= 1'b0;
            cal_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            tmo_pulse_q <= 1'b0;
            blank_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fifo_len_q  <= fifo_len_d;
            len_q       <= len_d;
            id_q        <= id_d;
            tmo_cnt_q   <= tmo_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            sc_ack_q    <= sc_ack_d;
            cal_ack_q   <= cal_ack_d;
            err_q       <= err_d;
            tmo_pulse_q <= tmo_pulse_d;
            blank_q     <= blank_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.sc_ack       = sc_ack_q;
    assign bus.cal_ack      = cal_ack_q;
    assign bus.fifo_len     = fifo_len_q;
    assign bus.blank        = blank_q;
    assign bus.busy         = busy_q;
    assign bus.err_range    = err_q;
    assign bus.sync_timeout = tmo_pulse_q;
endmodule

// File: tb/tb_tfc_delay_ctrl.sv
// Bench for tfc_delay_ctrl: ack/blank scoreboard fed by the request tasks, checked by a negedge monitor.
module tb_tfc_delay_ctrl;
    localparam int TW    = 8;
    localparam int MAXL  = 200;
    localparam int TMO   = 16;
    localparam int EXTRA = 2;

    typedef struct {
        bit cal;
        bit err;
        bit tmo;
        int len;
    } ack_exp_t;

    logic main_clk = 1'b0;
    logic rst_n    = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   model_len = 0;
    int   run       = 0;
    ack_exp_t ack_q[$];
    int       blank_q[$];
    ack_exp_t mon_e;

    tfc_delay_ctrl_if #(.TFC_WIDTH(TW)) ifc ();

    tfc_delay_ctrl #(
        .TFC_WIDTH(TW), .MAX_LEN(MAXL), .RESET_LEN(0), .SYNC_BIT(0),
        .BLANK_EXTRA(EXTRA), .SYNC_TIMEOUT(TMO)
    ) dut (
        .main_clk (main_clk),
        .rst_n    (rst_n),
        .bus      (ifc)
    );

    always #5 main_clk = ~main_clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] tfc_word(input bit sync);
        logic [TW-1:0] w;
        w    = TW'($urandom);
        w[0] = sync;
        return w;
    endfunction

    // Scoreboard consumer: every ack and every finished blank window must match the queued expectation.
    always @(negedge main_clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (ifc.sc_ack || ifc.cal_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    mon_e = ack_q.pop_front();
                    chk("ack_who", {ifc.cal_ack, ifc.sc_ack}, mon_e.cal ? 2 : 1);
                    chk("err_range", ifc.err_range, mon_e.err);
                    chk("sync_timeout", ifc.sync_timeout, mon_e.tmo);
                    chk("fifo_len_at_ack", ifc.fifo_len, mon_e.len);
                end
            end else if (ifc.err_range || ifc.sync_timeout) begin
                chk("stray_pulse", 1, 0);
            end
            if (ifc.blank) begin
                run++;
            end else if (run != 0) begin
                if (blank_q.size() == 0) chk("unexpected_blank", run, 0);
                else chk("blank_len", run, blank_q.pop_front());
                run = 0;
            end
        end
    end

    task automatic wait_not_busy(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 600 && cyc == 0; i++) begin
            @(posedge main_clk); #1;
            if (!ifc.busy) cyc = i;
        end
    endtask

    // One request from a single requester; sync_dly < 0 means no sync marker at all.
    task automatic issue(input bit cal, input int len, input int sync_dly, input string tag);
        ack_exp_t e;
        bit apply;
        int blank_n, exp_lat, n_ack, d;
        apply   = (len <= MAXL) && (len != model_len);
        blank_n = ((len > model_len) ? len - model_len : 0) + EXTRA + 1;
        e.cal   = cal;
        e.err   = (len > MAXL);
        e.tmo   = apply && (sync_dly < 0);
        e.len   = apply ? len : model_len;
        exp_lat = !apply ? 1 : (sync_dly < 0 ? TMO + 2 : sync_dly + 1);
        ack_q.push_back(e);
        if (apply) blank_q.push_back(blank_n);

        @(posedge main_clk); #1;
        if (cal) begin ifc.cal_req = 1'b1; ifc.cal_len = 8'(len); end
        else     begin ifc.sc_req  = 1'b1; ifc.sc_len  = 8'(len); end
        n_ack = 0;
        for (int n = 1; n <= 100 && n_ack == 0; n++) begin
            @(posedge main_clk); #1;
            ifc.tfc_in = tfc_word(n == sync_dly);
            if (n == 1) chk({tag, "_busy_t1"}, ifc.busy, apply);
            if (cal ? ifc.cal_ack : ifc.sc_ack) n_ack = n;
        end
        chk({tag, "_ack_latency"}, n_ack, exp_lat);
        wait_not_busy(d);
        ifc.sc_req  = 1'b0;
        ifc.cal_req = 1'b0;
        ifc.tfc_in  = '0;
        if (apply) chk({tag, "_busy_after_ack"}, d, blank_n);
        chk({tag, "_fifo_len"}, ifc.fifo_len, e.len);
        model_len = e.len;
    endtask

    initial begin
        int sc_at, cal_at, d;
        bit sc_drop, cal_drop;
        ack_exp_t e;
        ifc.sc_req  = 1'b0; ifc.sc_len  = '0;
        ifc.cal_req = 1'b0; ifc.cal_len = '0;
        ifc.tfc_in  = '0;
        repeat (3) @(posedge main_clk);
        #1;
        chk("rst_fifo_len", ifc.fifo_len, 0);
        chk("rst_outputs", {ifc.blank, ifc.busy, ifc.sc_ack, ifc.cal_ack, ifc.err_range, ifc.sync_timeout}, 0);
        rst_n = 1'b1;

        issue(0, 10, 5, "sc10");
        issue(1, 4, 2, "cal4");

        // Both requesters at once with sync always present: sc wins, cal waits for busy to drop.
        e = '{cal: 1'b0, err: 1'b0, tmo: 1'b0, len: 20}; ack_q.push_back(e); blank_q.push_back(16 + EXTRA + 1);
        e = '{cal: 1'b1, err: 1'b0, tmo: 1'b0, len: 30}; ack_q.push_back(e); blank_q.push_back(10 + EXTRA + 1);
        @(posedge main_clk); #1;
        ifc.sc_req = 1'b1;  ifc.sc_len  = 8'd20;
        ifc.cal_req = 1'b1; ifc.cal_len = 8'd30;
        ifc.tfc_in = tfc_word(1'b1);
        sc_at = 0; cal_at = 0; sc_drop = 0; cal_drop = 0;
        for (int i = 1; i <= 200 && cal_at == 0; i++) begin
            @(posedge main_clk); #1;
            ifc.tfc_in = tfc_word(1'b1);
            if (sc_drop) ifc.sc_req = 1'b0;
            if (cal_drop) ifc.cal_req = 1'b0;
            sc_drop = 0; cal_drop = 0;
            if (ifc.sc_ack)  begin sc_at = i;  sc_drop = 1; end
            if (ifc.cal_ack) begin cal_at = i; cal_drop = 1; end
        end
        chk("arb_sc_ack_cycle", sc_at, 2);
        chk("arb_cal_ack_cycle", cal_at, 2 + 19 + 2);
        wait_not_busy(d);
        ifc.sc_req = 1'b0; ifc.cal_req = 1'b0; ifc.tfc_in = '0;
        chk("arb_cal_busy_len", d, 13);
        chk("arb_fifo_len", ifc.fifo_len, 30);
        model_len = 30;

        issue(0, 201, -1, "range");
        issue(0, 40, -1, "timeout");
        issue(1, 200, 3, "max_len");
        issue(0, 200, -1, "same_len");
        issue(0, 100, 1, "down");

        // Reset in the middle of a blank window.
        e = '{cal: 1'b0, err: 1'b0, tmo: 1'b0, len: 180}; ack_q.push_back(e);
        @(posedge main_clk); #1;
        ifc.sc_req = 1'b1; ifc.sc_len = 8'd180;
        sc_at = 0;
        for (int i = 1; i <= 20 && sc_at == 0; i++) begin
            @(posedge main_clk); #1;
            ifc.tfc_in = tfc_word(i == 1);
            if (ifc.sc_ack) sc_at = i;
        end
        chk("rst_case_ack_cycle", sc_at, 2);
        @(posedge main_clk); #1;
        ifc.sc_req = 1'b0; ifc.tfc_in = '0;
        repeat (4) @(posedge main_clk);
        #1;
        chk("rst_case_blank_before", ifc.blank, 1);
        rst_n = 1'b0;
        @(posedge main_clk); #1;
        chk("rst_mid_fifo_len", ifc.fifo_len, 0);
        chk("rst_mid_outputs", {ifc.blank, ifc.busy, ifc.sc_ack, ifc.cal_ack, ifc.err_range, ifc.sync_timeout}, 0);
        rst_n = 1'b1;
        model_len = 0;
        issue(1, 9, 2, "post_rst");

        repeat (3) @(posedge main_clk);
        #1;
        chk("ack_queue_empty", ack_q.size(), 0);
        chk("blank_queue_empty", blank_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
